// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } arb_state_t;

    localparam int M0 = 0;
    localparam int M1 = 1;
    localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/wb_dual_master_arbiter_if.sv
// Bus bundle between the two CPU masters, the arbiter and the shared slave.
// The slave modport is the arbiter's view; the master modport is the surroundings.
interface wb_dual_master_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                  m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o;
    logic [ADDR_WIDTH-1:0] m0_adr_i;
    logic [DATA_WIDTH-1:0] m0_dat_i, m0_dat_o;
    logic [SEL_WIDTH-1:0]  m0_sel_i;

    logic                  m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o;
    logic [ADDR_WIDTH-1:0] m1_adr_i;
    logic [DATA_WIDTH-1:0] m1_dat_i, m1_dat_o;
    logic [SEL_WIDTH-1:0]  m1_sel_i;

    logic                  s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [ADDR_WIDTH-1:0] s_adr_o;
    logic [DATA_WIDTH-1:0] s_dat_o, s_dat_i;
    logic [SEL_WIDTH-1:0]  s_sel_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        output m0_ack_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        output m1_ack_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_dat_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        input  m0_ack_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        input  m1_ack_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_dat_i
    );

endinterface

// File: rtl/wb_arb_rr_fsm.sv
// Round-robin grant FSM with bus lock and a per-grant ack hold limit.
//   state  | meaning
//   IDLE   | no grant, late acks dropped
//   GNT_M0 | instruction-fetch master owns the bus
//   GNT_M1 | data master owns the bus
module wb_arb_rr_fsm
    import wb_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_cyc,
    input  logic       m1_cyc,
    input  logic       s_ack,
    output logic [1:0] gnt_o
);

    arb_state_t            state, state_nxt;
    logic                  last_gnt, last_gnt_nxt;
    logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic                  hold_limit;

    // True when the ack in flight would be the MAX_HOLD-th of this grant.
    assign hold_limit = ({1'b0, hold_cnt} + 5'd1) >= 5'(MAX_HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'(M1);
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        hold_cnt_nxt = hold_cnt;

        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc)
                    state_nxt = (last_gnt == 1'(M1)) ? GNT_M0 : GNT_M1;
                else if (m0_cyc)
                    state_nxt = GNT_M0;
                else if (m1_cyc)
                    state_nxt = GNT_M1;
            end
            GNT_M0: begin
                if (m0_cyc) begin
                    if (s_ack && hold_limit && m1_cyc)
                        state_nxt = GNT_M1;
                end else begin
                    state_nxt = m1_cyc ? GNT_M1 : IDLE;
                end
            end
            GNT_M1: begin
                if (m1_cyc) begin
                    if (s_ack && hold_limit && m0_cyc)
                        state_nxt = GNT_M0;
                end else begin
                    state_nxt = m0_cyc ? GNT_M0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state == IDLE || state_nxt != state)
            hold_cnt_nxt = '0;
        else if (s_ack && hold_cnt != '1)
            hold_cnt_nxt = hold_cnt + 1'b1;

        if (state_nxt == GNT_M0 && state != GNT_M0)
            last_gnt_nxt = 1'(M0);
        else if (state_nxt == GNT_M1 && state != GNT_M1)
            last_gnt_nxt = 1'(M1);
    end

    assign gnt_o = {state == GNT_M1, state == GNT_M0};

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone B4 classic arbiter: registered grant, combinational
// request mux towards the slave and ack demux back to the granted master.
module wb_dual_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    wb_dual_master_arbiter_if.slave   bus,
    output logic [1:0]                gnt_o
);

    logic                    cyc_mux, stb_mux, we_mux;
    logic [ADDR_WIDTH-1:0]   adr_mux;
    logic [DATA_WIDTH-1:0]   dat_mux;
    logic [DATA_WIDTH/8-1:0] sel_mux;

    wb_arb_rr_fsm #(.MAX_HOLD(MAX_HOLD)) u_fsm (
        .clk    (clk),
        .reset  (reset),
        .m0_cyc (bus.m0_cyc_i),
        .m1_cyc (bus.m1_cyc_i),
        .s_ack  (bus.s_ack_i),
        .gnt_o  (gnt_o)
    );

    always_comb begin
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        if (gnt_o[M0]) begin
            cyc_mux = bus.m0_cyc_i;
            stb_mux = bus.m0_stb_i;
            we_mux  = bus.m0_we_i;
            adr_mux = bus.m0_adr_i;
            dat_mux = bus.m0_dat_i;
            sel_mux = bus.m0_sel_i;
        end else if (gnt_o[M1]) begin
            cyc_mux = bus.m1_cyc_i;
            stb_mux = bus.m1_stb_i;
            we_mux  = bus.m1_we_i;
            adr_mux = bus.m1_adr_i;
            dat_mux = bus.m1_dat_i;
            sel_mux = bus.m1_sel_i;
        end
    end

    assign bus.s_cyc_o = cyc_mux;
    assign bus.s_stb_o = stb_mux;
    assign bus.s_we_o  = we_mux;
    assign bus.s_adr_o = adr_mux;
    assign bus.s_dat_o = dat_mux;
    assign bus.s_sel_o = sel_mux;

    // Acks raised while idle belong to an aborted cycle and are dropped here.
    assign bus.m0_ack_o = gnt_o[M0] & bus.s_ack_i;
    assign bus.m1_ack_o = gnt_o[M1] & bus.s_ack_i;
    assign bus.m0_dat_o = (gnt_o != 2'b00) ? bus.s_dat_i : '0;
    assign bus.m1_dat_o = (gnt_o != 2'b00) ? bus.s_dat_i : '0;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Self-checking bench: directed bus scenarios, read data scoreboarded per master.
module tb_wb_dual_master_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] gnt;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    wb_dual_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_dual_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .gnt_o (gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Ack monitor: every ack delivered to a master must match its next expected data.
    always @(negedge clk) begin
        if (!reset) begin
            if (q0.size() == 0) chk("m0_ack_unexpected", 32'(bus.m0_ack_o), 32'd0);
            else if (bus.m0_ack_o) chk("m0_rdata", bus.m0_dat_o, q0.pop_front());
            if (q1.size() == 0) chk("m1_ack_unexpected", 32'(bus.m1_ack_o), 32'd0);
            else if (bus.m1_ack_o) chk("m1_rdata", bus.m1_dat_o, q1.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;
        bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_sel_i = '0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
        bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_sel_i = '0;
        bus.s_ack_i = 0; bus.s_dat_i = '0;

        // reset then idle
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
        chk("rst_s_stb", 32'(bus.s_stb_o), 32'd0);
        chk("rst_s_adr", bus.s_adr_o, 32'd0);
        tick();
        chk("idle_gnt", 32'(gnt), 32'd0);

        // single master read on m1
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h8040_0000; bus.m1_sel_i = 4'hF;
        #1;
        chk("m1_req_gnt_latency", 32'(gnt), 32'd0);
        chk("m1_req_no_fwd", 32'(bus.s_cyc_o), 32'd0);
        tick();
        chk("m1_gnt", 32'(gnt), 32'd2);
        chk("m1_s_cyc", 32'(bus.s_cyc_o), 32'd1);
        chk("m1_s_adr", bus.s_adr_o, 32'h8040_0000);
        tick();
        bus.s_ack_i = 1; bus.s_dat_i = 32'hDEAD_BEEF;
        q1.push_back(32'hDEAD_BEEF);
        #1;
        chk("m1_ack", 32'(bus.m1_ack_o), 32'd1);
        chk("m1_ack_not_m0", 32'(bus.m0_ack_o), 32'd0);
        tick();
        bus.s_ack_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        tick();
        chk("m1_done_idle", 32'(gnt), 32'd0);

        // tie after reset: m0 wins, release hands straight to m1
        do_reset();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1;
        bus.m0_adr_i = 32'h0000_00A0; bus.m0_dat_i = 32'hCAFE_0001; bus.m0_sel_i = 4'hF;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 0;
        bus.m1_adr_i = 32'h0000_00A1; bus.m1_sel_i = 4'h3;
        tick();
        chk("tie_gnt_m0", 32'(gnt), 32'd1);
        chk("tie_s_adr", bus.s_adr_o, 32'h0000_00A0);
        chk("tie_s_we", 32'(bus.s_we_o), 32'd1);
        chk("tie_s_dat", bus.s_dat_o, 32'hCAFE_0001);
        chk("tie_s_sel", 32'(bus.s_sel_o), 32'hF);
        bus.s_ack_i = 1; bus.s_dat_i = 32'h1111_0000;
        q0.push_back(32'h1111_0000);
        tick();
        bus.s_ack_i = 0;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;
        #1;
        chk("release_s_cyc_drop", 32'(bus.s_cyc_o), 32'd0);
        tick();
        chk("release_gnt_m1", 32'(gnt), 32'd2);
        chk("release_s_adr", bus.s_adr_o, 32'h0000_00A1);
        chk("release_s_sel", 32'(bus.s_sel_o), 32'h3);
        bus.s_ack_i = 1; bus.s_dat_i = 32'h2222_0000;
        q1.push_back(32'h2222_0000);
        tick();
        bus.s_ack_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        tick();
        chk("tie_done_idle", 32'(gnt), 32'd0);

        // hold limit: m0 locks for 6 accesses, m1 waiting
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 32'h0000_0100;
        tick();
        chk("hold_gnt_m0", 32'(gnt), 32'd1);
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h0000_0B00;
        for (int k = 0; k < 4; k++) begin
            bus.s_ack_i = 1; bus.s_dat_i = 32'h1000_0000 + 32'(k);
            bus.m0_adr_i = 32'h0000_0100 + 32'(k * 4);
            q0.push_back(32'h1000_0000 + 32'(k));
            #1;
            chk("hold_locked_gnt", 32'(gnt), 32'd1);
            chk("hold_locked_adr", bus.s_adr_o, 32'h0000_0100 + 32'(k * 4));
            tick();
        end
        bus.s_ack_i = 0;
        bus.m0_adr_i = 32'h0000_0110;
        #1;
        chk("hold_switch_gnt", 32'(gnt), 32'd2);
        chk("hold_switch_adr", bus.s_adr_o, 32'h0000_0B00);
        bus.s_ack_i = 1; bus.s_dat_i = 32'h3333_0000;
        q1.push_back(32'h3333_0000);
        #1;
        chk("hold_m0_no_ack", 32'(bus.m0_ack_o), 32'd0);
        tick();
        bus.s_ack_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        #1;
        chk("hold_m0_stb_blocked", 32'(bus.s_stb_o), 32'd0);
        tick();
        chk("hold_back_to_m0", 32'(gnt), 32'd1);
        chk("hold_back_adr", bus.s_adr_o, 32'h0000_0110);
        for (int k = 4; k < 6; k++) begin
            bus.s_ack_i = 1; bus.s_dat_i = 32'h1000_0000 + 32'(k);
            q0.push_back(32'h1000_0000 + 32'(k));
            tick();
        end
        bus.s_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        tick();
        chk("hold_done_idle", 32'(gnt), 32'd0);

        // abort with a late ack
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h0000_0C00;
        tick();
        chk("abort_gnt_m1", 32'(gnt), 32'd2);
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        #1;
        chk("abort_s_cyc_same_cycle", 32'(bus.s_cyc_o), 32'd0);
        chk("abort_s_stb_same_cycle", 32'(bus.s_stb_o), 32'd0);
        tick();
        bus.s_ack_i = 1; bus.s_dat_i = 32'hBAD0_BAD0;
        #1;
        chk("late_ack_gnt", 32'(gnt), 32'd0);
        chk("late_ack_m0", 32'(bus.m0_ack_o), 32'd0);
        chk("late_ack_m1", 32'(bus.m1_ack_o), 32'd0);
        tick();
        bus.s_ack_i = 0;

        // reset mid-transaction, pending m0 wins afterwards
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h0000_0D00;
        tick();
        chk("midrst_gnt_m1", 32'(gnt), 32'd2);
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 32'h0000_0E00;
        reset = 1;
        tick();
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
        reset = 0;
        tick();
        chk("midrst_m0_first", 32'(gnt), 32'd1);
        chk("midrst_m0_adr", bus.s_adr_o, 32'h0000_0E00);
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        tick();
        tick();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_dual_master_arbiter.md
# wb_dual_master_arbiter

Two-master Wishbone B4 classic arbiter between the CPU core and the shared SRAM/peripheral bus. Master 0 is the instruction-fetch port, master 1 the data (MEM stage) port. Granting is registered, with round-robin fairness, bus locking and a per-grant hold limit. Address, data, select and write-enable of the granted master go to one slave port, and ack is routed back only to that master.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8
- MAX_HOLD, 4, acks a master may complete in one continuous grant while the other master waits (1..15)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  single clock
  - reset  in  1  synchronous, active-high
- Master 0 (instruction fetch):
  - m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
  - m0_adr_i  in  ADDR_WIDTH ; m0_dat_i  in  DATA_WIDTH ; m0_sel_i  in  DATA_WIDTH/8
  - m0_ack_o  out  1 ; m0_dat_o  out  DATA_WIDTH
- Master 1 (data): m1_* , same set as m0_*
- Slave side:
  - s_cyc_o, s_stb_o, s_we_o  out  1 each
  - s_adr_o  out  ADDR_WIDTH ; s_dat_o  out  DATA_WIDTH ; s_sel_o  out  DATA_WIDTH/8
  - s_ack_i  in  1 ; s_dat_i  in  DATA_WIDTH
- Status:
  - gnt_o  out  2  one-hot grant: bit0 = m0, bit1 = m1; 00 in IDLE

## Operation
- States:
  - IDLE: no grant.
  - GNT_M0: master 0 owns the bus.
  - GNT_M1: master 1 owns the bus.
- IDLE transitions:
  - Exactly one cyc high: move to that master's grant state.
  - Both cyc high: grant the master that is not last_gnt.
  - last_gnt resets to M1, so master 0 wins the first tie.
- In GNT_x:
  - Slave outputs carry master x's signals.
  - x_ack_o = s_ack_i; the other master's ack_o = 0.
  - Both masters receive s_dat_i on dat_o. Only the acked master samples it.
- Leaving GNT_x, with x's cyc high (bus lock):
  - The grant stays while x_cyc_i is high.
  - Exception: on a cycle where s_ack_i=1, hold_cnt+1 ≥ MAX_HOLD and the other cyc is high, the next state is GNT_other.
- Leaving GNT_x, with x's cyc low:
  - If the other cyc is high, go directly to GNT_other.
  - Otherwise go to IDLE.
- hold_cnt:
  - 4-bit; clears on every grant change and in IDLE.
  - Increments on each s_ack_i in a grant state, saturating at 15.
- last_gnt is updated on entry to each grant state.
- Output values:
  - IDLE: all s_* outputs are 0, both ack_o are 0, gnt_o = 00.
  - Grant states: s_cyc_o = granted cyc; s_stb_o = granted stb.
- Abort: if the granted master drops cyc mid-transaction, s_cyc_o/s_stb_o fall in the same cycle. A late s_ack_i arriving in IDLE is discarded.
- A stb from a non-granted master never reaches the slave. That master waits with its signals held, per Wishbone.

## Timing
- Reset: at the reset edge, state = IDLE, last_gnt = M1 and hold_cnt = 0. All outputs are 0 in the following cycle.
- Grant latency: a request in IDLE at edge n gives gnt_o and s_cyc_o at edge n+1. That is one cycle of arbitration overhead.
- Steady state: within a grant, slave outputs and ack routing are combinational from the state register, so there is zero added latency per access. Back-to-back locked accesses run at full slave rate.
- Handoff:
  - Release: x drops cyc at edge n, the other master is granted at n+1, with no idle cycle.
  - Hold-limit switch: the ack at edge n is delivered to x, and the other master is granted at n+1.
  - x sees no stb forwarded from n+1 onward.
- Simultaneous first requests from IDLE: the non-last_gnt master wins.
- Reset asserted mid-transaction: drops the grant at the next edge regardless of cyc/ack.

## Structure
- Package wb_arb_pkg:
  - arb_state_t enum {IDLE, GNT_M0, GNT_M1}
  - master index localparams M0=0, M1=1
  - HOLD_CNT_W=4
- One natural sub-module: wb_arb_rr_fsm, holding the state, last_gnt and hold_cnt registers and the next-state logic, with gnt_o as output.
- The top level is the datapath mux and ack demux driven by gnt_o.

## Test plan
- Reset then idle: reset held for 2 cycles, no cyc → all s_* = 0, gnt_o = 00. After release, still 00.
- Single master: m1 read at adr 0x8040_0000, slave acks 2 cycles later with 0xDEAD_BEEF → gnt_o = 10 one cycle after m1_cyc. m1_ack_o = 1 with m1_dat_o = 0xDEAD_BEEF. m0_ack_o stays 0.
- Tie from IDLE after reset: m0 and m1 both raise cyc in the same cycle → m0 granted first (gnt_o = 01). On m0 release, m1 is granted the next cycle with no IDLE gap.
- Hold limit: m0 holds cyc for 6 single-cycle-ack accesses while m1 waits, MAX_HOLD = 4 → after m0's 4th ack, gnt_o = 10 the next cycle. m0's stb is not forwarded until m1 drops cyc.
- Abort and late ack: m1 drops cyc before ack, then the slave asserts s_ack_i one cycle later → state IDLE, neither ack_o asserted.
- Reset mid-transaction: reset asserted while GNT_M1 with stb high → gnt_o = 00 and s_cyc_o = 0 at the next edge. After release, a pending m0 request is granted first (last_gnt = M1).
